// File: rtl/adc_scan_pkg.sv
// rtl/adc_scan_pkg.sv - shared types, widths and frame encoding for the ADC scan sequencer
package adc_scan_pkg;

    localparam int DATA_W    = 12;
    localparam int CH_W      = 3;
    localparam int FRAME_LEN = 3;

    // Start bit and single-ended select, followed by the channel MSB in byte 0.
    localparam logic [4:0] ADC_START_SGL = 5'b00011;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CS_SETUP,
        ST_SEND,
        ST_WAIT_RX,
        ST_CS_HOLD,
        ST_NEXT
    } state_e;

    // Byte idx of the 3-byte conversion frame for channel ch.
    function automatic logic [7:0] frame_byte(input logic [CH_W-1:0] ch, input logic [1:0] idx);
        case (idx)
            2'd0:    frame_byte = {2'b00, ADC_START_SGL, ch[2]};
            2'd1:    frame_byte = {ch[1:0], 6'b000000};
            default: frame_byte = 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/adc_scan_tick.sv
// rtl/adc_scan_tick.sv - periodic scan tick generator
// Ports: i_Clk clock, i_Rst async active-high reset, i_Enable counting enable,
//        o_Tick one-cycle pulse every SAMPLE_DIV enabled cycles.
module adc_scan_tick #(
    parameter int SAMPLE_DIV = 12000
) (
    input  logic i_Clk,
    input  logic i_Rst,
    input  logic i_Enable,
    output logic o_Tick
);

    localparam int CNT_W = $clog2(SAMPLE_DIV);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             last;

    assign last = (cnt_q == CNT_W'(SAMPLE_DIV - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (!i_Enable || last) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Gated by i_Enable so a tick coinciding with disable is dropped.
    assign o_Tick = i_Enable && last;

endmodule

// File: rtl/adc_scan_ctrl.sv
// rtl/adc_scan_ctrl.sv - periodic multi-channel SAR ADC scan sequencer on a byte SPI master
// Ports: i_Clk/i_Rst clock and async active-high reset; i_Enable scan enable;
//        i_TX_Ready/o_TX_DV/o_TX_Byte byte request to the SPI master;
//        i_RX_DV/i_RX_Byte byte returned by the SPI master; o_SPI_CS_n ADC select;
//        o_Sample_Valid/o_Sample_Data/o_Sample_Ch result strobe; o_Scan_Done last channel;
//        o_Overrun tick lost while busy; o_Busy sequencer active.
module adc_scan_ctrl
    import adc_scan_pkg::*;
#(
    parameter int NUM_CH     = 4,
    parameter int SAMPLE_DIV = 12000,
    parameter int CS_SETUP   = 2,
    parameter int CS_HOLD    = 2
) (
    input  logic              i_Clk,
    input  logic              i_Rst,
    input  logic              i_Enable,
    input  logic              i_TX_Ready,
    input  logic              i_RX_DV,
    input  logic [7:0]        i_RX_Byte,
    output logic [7:0]        o_TX_Byte,
    output logic              o_TX_DV,
    output logic              o_SPI_CS_n,
    output logic              o_Sample_Valid,
    output logic [DATA_W-1:0] o_Sample_Data,
    output logic [CH_W-1:0]   o_Sample_Ch,
    output logic              o_Scan_Done,
    output logic              o_Overrun,
    output logic              o_Busy
);

    localparam int WAIT_W = 8;
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

    state_e              state_q, state_d;
    logic [CH_W-1:0]     ch_q, ch_d;
    logic [1:0]          idx_q, idx_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic [3:0]          hi_q, hi_d;
    logic [DATA_W-1:0]   smp_data_q, smp_data_d;
    logic [CH_W-1:0]     smp_ch_q, smp_ch_d;
    logic                smp_valid_q, smp_valid_d;
    logic                done_q, done_d;
    logic                ovr_q, ovr_d;
    logic                tick;

    adc_scan_tick #(
        .SAMPLE_DIV (SAMPLE_DIV)
    ) u_tick (
        .i_Clk    (i_Clk),
        .i_Rst    (i_Rst),
        .i_Enable (i_Enable),
        .o_Tick   (tick)
    );

    always_comb begin
        state_d     = state_q;
        ch_d        = ch_q;
        idx_d       = idx_q;
        wait_d      = wait_q;
        hi_d        = hi_q;
        smp_data_d  = smp_data_q;
        smp_ch_d    = smp_ch_q;
        smp_valid_d = 1'b0;
        done_d      = 1'b0;
        ovr_d       = tick && (state_q != ST_IDLE);

        case (state_q)
            ST_IDLE: begin
                if (tick) begin
                    state_d = ST_CS_SETUP;
                    ch_d    = '0;
                    wait_d  = '0;
                end
            end
            ST_CS_SETUP: begin
                if (wait_q == WAIT_W'(CS_SETUP - 1)) begin
                    state_d = ST_SEND;
                    idx_d   = '0;
                    wait_d  = '0;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            ST_SEND: begin
                if (i_TX_Ready) begin
                    state_d = ST_WAIT_RX;
                end
            end
            ST_WAIT_RX: begin
                if (i_RX_DV) begin
                    // Reply to byte 0 carries no data; byte 1 low nibble is data[11:8].
                    if (idx_q == 2'd1) begin
                        hi_d = i_RX_Byte[3:0];
                    end
                    if (idx_q == 2'(FRAME_LEN - 1)) begin
                        state_d     = ST_CS_HOLD;
                        wait_d      = '0;
                        smp_valid_d = 1'b1;
                        smp_data_d  = {hi_q, i_RX_Byte};
                        smp_ch_d    = ch_q;
                        done_d      = (ch_q == LAST_CH);
                    end else begin
                        state_d = ST_SEND;
                        idx_d   = idx_q + 1'b1;
                    end
                end
            end
            ST_CS_HOLD: begin
                if (wait_q == WAIT_W'(CS_HOLD - 1)) begin
                    state_d = ST_NEXT;
                    wait_d  = '0;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            ST_NEXT: begin
                // CS_n high time between frames; a disable ends the scan here.
                if (wait_q == WAIT_W'(CS_HOLD - 1)) begin
                    wait_d = '0;
                    if ((ch_q != LAST_CH) && i_Enable) begin
                        state_d = ST_CS_SETUP;
                        ch_d    = ch_q + 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state_q     <= ST_IDLE;
            ch_q        <= '0;
            idx_q       <= '0;
            wait_q      <= '0;
            hi_q        <= '0;
            smp_data_q  <= '0;
            smp_ch_q    <= '0;
            smp_valid_q <= 1'b0;
            done_q      <= 1'b0;
            ovr_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            ch_q        <= ch_d;
            idx_q       <= idx_d;
            wait_q      <= wait_d;
            hi_q        <= hi_d;
            smp_data_q  <= smp_data_d;
            smp_ch_q    <= smp_ch_d;
            smp_valid_q <= smp_valid_d;
            done_q      <= done_d;
            ovr_q       <= ovr_d;
        end
    end

    // Decoded from state so reset releases CS_n and kills TX_DV immediately.
    assign o_Busy         = (state_q != ST_IDLE);
    assign o_SPI_CS_n     = (state_q == ST_IDLE) || (state_q == ST_NEXT);
    assign o_TX_DV        = (state_q == ST_SEND) && i_TX_Ready;
    assign o_TX_Byte      = (state_q == ST_SEND) ? frame_byte(ch_q, idx_q) : 8'h00;
    assign o_Sample_Valid = smp_valid_q;
    assign o_Sample_Data  = smp_data_q;
    assign o_Sample_Ch    = smp_ch_q;
    assign o_Scan_Done    = done_q;
    assign o_Overrun      = ovr_q;

endmodule
